snoop_cache_responder: RTL and testbench

SNOOP_CACHE_RESPONDER -- requirements
Module: snoop_cache_responder

---
 rtl/snoop_pkg.sv | 62 ++++++
 rtl/snoop_resp_decoder.sv | 56 +++++
 rtl/snoop_cache_responder.sv | 165 ++++++++++++++++
 tb/tb_snoop_cache_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/snoop_pkg.sv
//------------------------------------------------------------------------------
// Module      : snoop_pkg
// Description : Shared types and encodings for the snoop cache responder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package snoop_pkg;

    localparam int SNOOP_ADDR_W = 32;
    localparam int SNOOP_DATA_W = 64;

    // CRRESP bit positions: {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    localparam int CR_DATA_XFER  = 0;
    localparam int CR_ERROR      = 1;
    localparam int CR_PASS_DIRTY = 2;
    localparam int CR_IS_SHARED  = 3;
    localparam int CR_WAS_UNIQUE = 4;
    localparam int CR_W          = 5;

    localparam logic [1:0] UPD_KEEP         = 2'b00;
    localparam logic [1:0] UPD_SHARED_CLEAN = 2'b01;
    localparam logic [1:0] UPD_INVALID      = 2'b10;

    localparam logic [3:0] AC_READ_SHARED   = 4'b0001;
    localparam logic [3:0] AC_READ_CLEAN    = 4'b0010;
    localparam logic [3:0] AC_READ_UNIQUE   = 4'b0111;
    localparam logic [3:0] AC_CLEAN_INVALID = 4'b1001;
    localparam logic [3:0] AC_MAKE_INVALID  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_CR     = 2'd2,
        S_CD     = 2'd3
    } snoop_state_e;

    typedef struct packed {
        logic                    ac_valid;
        logic [SNOOP_ADDR_W-1:0] ac_addr;
        logic [3:0]              ac_snoop;
        logic                    cr_ready;
        logic                    cd_ready;
    } snoop_req_s;

    typedef struct packed {
        logic                    ac_ready;
        logic                    cr_valid;
        logic [CR_W-1:0]         cr_resp;
        logic                    cd_valid;
        logic [SNOOP_DATA_W-1:0] cd_data;
        logic                    cd_last;
    } snoop_resp_s;

    function automatic logic is_invalidating(input logic [3:0] snoop);
        return (snoop == AC_READ_UNIQUE) || (snoop == AC_CLEAN_INVALID) ||
               (snoop == AC_MAKE_INVALID);
    endfunction

endpackage

`default_nettype wire

// File: rtl/snoop_resp_decoder.sv
//------------------------------------------------------------------------------
// Module      : snoop_resp_decoder
// Description : Derives CRRESP, data-transfer flag and line-state update.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module snoop_resp_decoder
    import snoop_pkg::*;
(
    input  logic [3:0]      acsnoop_i,
    input  logic            hit_i,
    input  logic            dirty_i,
    input  logic            shared_i,
    output logic [CR_W-1:0] crresp_o,
    output logic            data_xfer_o,
    output logic            upd_valid_o,
    output logic [1:0]      upd_state_o
);

    always_comb begin
        crresp_o    = '0;
        upd_valid_o = 1'b0;
        upd_state_o = UPD_KEEP;
        case (acsnoop_i)
            AC_READ_SHARED, AC_READ_CLEAN: begin
                crresp_o[CR_DATA_XFER]  = hit_i;
                crresp_o[CR_PASS_DIRTY] = hit_i & dirty_i;
                crresp_o[CR_IS_SHARED]  = hit_i;
                crresp_o[CR_WAS_UNIQUE] = hit_i & ~shared_i;
                upd_valid_o             = hit_i;
                upd_state_o             = hit_i ? UPD_SHARED_CLEAN : UPD_KEEP;
            end
            AC_READ_UNIQUE, AC_CLEAN_INVALID: begin
                crresp_o[CR_DATA_XFER]  = hit_i;
                crresp_o[CR_PASS_DIRTY] = hit_i & dirty_i;
                crresp_o[CR_WAS_UNIQUE] = hit_i & ~shared_i;
                upd_valid_o             = hit_i;
                upd_state_o             = hit_i ? UPD_INVALID : UPD_KEEP;
            end
            AC_MAKE_INVALID: begin
                // The line is discarded without data, so only uniqueness is reported
                crresp_o[CR_WAS_UNIQUE] = hit_i & ~shared_i;
                upd_valid_o             = hit_i;
                upd_state_o             = hit_i ? UPD_INVALID : UPD_KEEP;
            end
            default: begin
                crresp_o[CR_ERROR] = 1'b1;
            end
        endcase
        data_xfer_o = crresp_o[CR_DATA_XFER];
    end

endmodule

`default_nettype wire

// File: rtl/snoop_cache_responder.sv
//------------------------------------------------------------------------------
// Module      : snoop_cache_responder
// Description : Serves one ACE snoop at a time: lookup, CR response, CD beats.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module snoop_cache_responder
    import snoop_pkg::*;
#(
    parameter int  AddrWidth    = 32,
    parameter int  DataWidth    = 64,
    parameter int  CdBeats      = 4,
    parameter type snoop_req_t  = snoop_req_s,
    parameter type snoop_resp_t = snoop_resp_s
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  snoop_req_t                   snoop_req_i,
    output snoop_resp_t                  snoop_resp_o,
    output logic                         lookup_valid_o,
    output logic [AddrWidth-1:0]         lookup_addr_o,
    input  logic                         lookup_ready_i,
    input  logic                         hit_i,
    input  logic                         dirty_i,
    input  logic                         shared_i,
    input  logic [CdBeats*DataWidth-1:0] line_i,
    output logic                         upd_valid_o,
    output logic [1:0]                   upd_state_o
);

    localparam int                BEAT_W    = $clog2(CdBeats);
    localparam int                LINE_W    = CdBeats * DataWidth;
    localparam int                OFFS_W    = $clog2(LINE_W / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CdBeats - 1);

    snoop_state_e          state_q;
    logic                  ac_ready_q;
    logic                  lookup_valid_q;
    logic                  cr_valid_q;
    logic                  cd_valid_q;
    logic                  upd_valid_q;
    logic [1:0]            upd_state_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [BEAT_W-1:0]     beat_d;
    logic [AddrWidth-1:0]  addr_q;
    logic [3:0]            snoop_q;
    logic                  hit_q;
    logic                  dirty_q;
    logic                  shared_q;
    logic [LINE_W-1:0]     line_q;

    logic [CR_W-1:0]       w_crresp;
    logic                  w_data_xfer;
    logic                  w_upd_valid;
    logic [1:0]            w_upd_state;
    logic [DataWidth-1:0]  w_beat_data;

    // Decoder works on latched lookup state so CRRESP is stable for the whole CR phase
    snoop_resp_decoder u_decoder (
        .acsnoop_i   (snoop_q),
        .hit_i       (hit_q),
        .dirty_i     (dirty_q),
        .shared_i    (shared_q),
        .crresp_o    (w_crresp),
        .data_xfer_o (w_data_xfer),
        .upd_valid_o (w_upd_valid),
        .upd_state_o (w_upd_state)
    );

    assign beat_d      = beat_q + 1'b1;
    assign w_beat_data = line_q[beat_q * DataWidth +: DataWidth];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            ac_ready_q     <= 1'b1;
            lookup_valid_q <= 1'b0;
            cr_valid_q     <= 1'b0;
            cd_valid_q     <= 1'b0;
            upd_valid_q    <= 1'b0;
            upd_state_q    <= UPD_KEEP;
            beat_q         <= '0;
            addr_q         <= '0;
            snoop_q        <= '0;
            hit_q          <= 1'b0;
            dirty_q        <= 1'b0;
            shared_q       <= 1'b0;
            line_q         <= '0;
        end else begin
            upd_valid_q <= 1'b0;
            upd_state_q <= UPD_KEEP;
            case (state_q)
                S_IDLE: begin
                    if (snoop_req_i.ac_valid && ac_ready_q) begin
                        addr_q         <= snoop_req_i.ac_addr;
                        snoop_q        <= snoop_req_i.ac_snoop;
                        ac_ready_q     <= 1'b0;
                        lookup_valid_q <= 1'b1;
                        state_q        <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (lookup_ready_i) begin
                        hit_q          <= hit_i;
                        dirty_q        <= dirty_i;
                        shared_q       <= shared_i;
                        line_q         <= line_i;
                        lookup_valid_q <= 1'b0;
                        cr_valid_q     <= 1'b1;
                        state_q        <= S_CR;
                    end
                end
                S_CR: begin
                    if (snoop_req_i.cr_ready) begin
                        cr_valid_q  <= 1'b0;
                        upd_valid_q <= w_upd_valid;
                        upd_state_q <= w_upd_state;
                        if (w_data_xfer) begin
                            cd_valid_q <= 1'b1;
                            beat_q     <= '0;
                            state_q    <= S_CD;
                        end else begin
                            ac_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end
                    end
                end
                S_CD: begin
                    if (snoop_req_i.cd_ready) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q     <= '0;
                            cd_valid_q <= 1'b0;
                            ac_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            beat_q <= beat_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        snoop_resp_o          = '0;
        snoop_resp_o.ac_ready = ac_ready_q;
        snoop_resp_o.cr_valid = cr_valid_q;
        snoop_resp_o.cr_resp  = cr_valid_q ? w_crresp : '0;
        snoop_resp_o.cd_valid = cd_valid_q;
        snoop_resp_o.cd_data  = cd_valid_q ? w_beat_data : '0;
        snoop_resp_o.cd_last  = cd_valid_q && (beat_q == LAST_BEAT);
    end

    assign lookup_valid_o = lookup_valid_q;
    assign lookup_addr_o  = {addr_q[AddrWidth-1:OFFS_W], OFFS_W'(0)};
    assign upd_valid_o    = upd_valid_q;
    assign upd_state_o    = upd_state_q;

endmodule

`default_nettype wire

// File: tb/tb_snoop_cache_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_snoop_cache_responder
// Description : Directed self-checking bench for snoop_cache_responder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_snoop_cache_responder;
    import snoop_pkg::*;

    localparam int LW = 256;

    logic        clk;
    logic        rst;
    snoop_req_s  req;
    snoop_resp_s resp;
    logic        lookup_valid;
    logic [31:0] lookup_addr;
    logic        lookup_ready;
    logic        hit, dirty, shared;
    logic [LW-1:0] line;
    logic        upd_valid;
    logic [1:0]  upd_state;

    int n_tests = 0;
    int n_fail  = 0;

    snoop_cache_responder dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .snoop_req_i    (req),
        .snoop_resp_o   (resp),
        .lookup_valid_o (lookup_valid),
        .lookup_addr_o  (lookup_addr),
        .lookup_ready_i (lookup_ready),
        .hit_i          (hit),
        .dirty_i        (dirty),
        .shared_i       (shared),
        .line_i         (line),
        .upd_valid_o    (upd_valid),
        .upd_state_o    (upd_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {upd_valid, upd_state[1:0], crresp[4:0]}
    function automatic logic [7:0] model(input logic [3:0] snp, input logic h, input logic d,
                                         input logic s);
        logic [4:0] r;
        logic       uv;
        logic [1:0] us;
        r = 5'b0; uv = 1'b0; us = 2'b00;
        case (snp)
            4'b0001, 4'b0010: begin r = {h & ~s, h, h & d, 1'b0, h}; uv = h; us = 2'b01; end
            4'b0111, 4'b1001: begin r = {h & ~s, 1'b0, h & d, 1'b0, h}; uv = h; us = 2'b10; end
            4'b1101:          begin r = {h & ~s, 4'b0000}; uv = h; us = 2'b10; end
            default:          r = 5'b00010;
        endcase
        if (!uv) us = 2'b00;
        return {uv, us, r};
    endfunction

    function automatic logic [LW-1:0] mk_line(input logic [63:0] seed);
        return {seed ^ 64'h3333_0000_0000_0003, seed ^ 64'h2222_0000_0000_0002,
                seed ^ 64'h1111_0000_0000_0001, seed};
    endfunction

    // Called and returns just after a falling edge; drives one full snoop
    task automatic run_snoop(input logic [31:0] addr, input logic [3:0] snp, input logic h,
                             input logic d, input logic s, input logic [LW-1:0] ln,
                             input bit stall_cr, input bit stall_cd);
        logic [7:0] e;
        e = model(snp, h, d, s);
        check("ac_ready_idle", resp.ac_ready, 1);
        req.ac_valid = 1'b1; req.ac_addr = addr; req.ac_snoop = snp;
        @(negedge clk);
        req.ac_valid = 1'b0;
        check("lookup_valid", lookup_valid, 1);
        check("lookup_addr", lookup_addr, {addr[31:5], 5'b0});
        check("ac_ready_busy", resp.ac_ready, 0);
        lookup_ready = 1'b1; hit = h; dirty = d; shared = s; line = ln;
        @(negedge clk);
        lookup_ready = 1'b0; line = ~ln;
        check("lookup_drop", lookup_valid, 0);
        check("cr_valid", resp.cr_valid, 1);
        check("crresp", resp.cr_resp, e[4:0]);
        check("cd_before_cr", resp.cd_valid, 0);
        if (stall_cr) begin
            @(negedge clk);
            check("cr_hold_valid", resp.cr_valid, 1);
            check("cr_hold_resp", resp.cr_resp, e[4:0]);
            check("upd_early", upd_valid, 0);
        end
        req.cr_ready = 1'b1;
        @(negedge clk);
        req.cr_ready = 1'b0;
        check("cr_drop", resp.cr_valid, 0);
        check("upd_valid", upd_valid, e[7]);
        check("upd_state", upd_state, e[6:5]);
        if (e[0]) begin
            for (int k = 0; k < 4; k++) begin
                check("cd_valid", resp.cd_valid, 1);
                check("cd_data", resp.cd_data, ln[k*64 +: 64]);
                check("cd_last", resp.cd_last, (k == 3));
                if (stall_cd) begin
                    req.cd_ready = 1'b0;
                    @(negedge clk);
                    check("cd_hold", resp.cd_data, ln[k*64 +: 64]);
                end
                req.cd_ready = 1'b1;
                @(negedge clk);
                check("upd_pulse_len", upd_valid, 0);
            end
            req.cd_ready = 1'b0;
        end
        check("cd_done", resp.cd_valid, 0);
        check("ac_ready_back", resp.ac_ready, 1);
    endtask

    initial begin
        logic [LW-1:0] ln;
        rst = 1'b1; req = '0; lookup_ready = 1'b0;
        hit = 1'b0; dirty = 1'b0; shared = 1'b0; line = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ac_ready", resp.ac_ready, 1);
        check("rst_cr_valid", resp.cr_valid, 0);
        check("rst_crresp", resp.cr_resp, 0);
        check("rst_cd_valid", resp.cd_valid, 0);
        check("rst_lookup", lookup_valid, 0);
        check("rst_upd", upd_valid, 0);

        run_snoop(32'h0000_0100, 4'b0001, 1, 1, 0, mk_line(64'hA000_0000_0000_0100), 0, 0);
        run_snoop(32'h0000_2244, 4'b0111, 0, 0, 0, mk_line(64'hB000_0000_0000_0200), 0, 0);
        run_snoop(32'h0001_003F, 4'b1001, 1, 0, 1, mk_line(64'hC000_0000_0000_0300), 0, 1);
        run_snoop(32'h0000_0480, 4'b0011, 1, 1, 0, mk_line(64'hD000_0000_0000_0400), 0, 0);
        run_snoop(32'h0000_0500, 4'b1101, 1, 1, 0, mk_line(64'hE000_0000_0000_0500), 0, 0);
        run_snoop(32'hFFFF_FFE7, 4'b0010, 1, 0, 1, mk_line(64'hF000_0000_0000_0600), 1, 0);
        run_snoop(32'h0000_0700, 4'b0111, 1, 1, 1, mk_line(64'h1234_5678_9ABC_DEF0), 0, 0);

        // Every acsnoop code with a varied line state
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            logic [3:0]  sn;
            a  = i * 32'h44;
            sn = i[3:0];
            run_snoop(a, sn, (i != 5), i[2], i[3], mk_line(64'h5500_0000_0000_0000 + i), 0, 0);
        end

        // Reset asserted while beat 2 is on the CD channel
        ln = mk_line(64'h7700_0000_0000_0077);
        req.ac_valid = 1'b1; req.ac_addr = 32'h900; req.ac_snoop = 4'b0001;
        @(negedge clk);
        req.ac_valid = 1'b0;
        lookup_ready = 1'b1; hit = 1'b1; dirty = 1'b0; shared = 1'b0; line = ln;
        @(negedge clk);
        lookup_ready = 1'b0; req.cr_ready = 1'b1;
        @(negedge clk);
        req.cr_ready = 1'b0; req.cd_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst_beat2", resp.cd_data, ln[128 +: 64]);
        req.cd_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_cd_drop", resp.cd_valid, 0);
        check("rst_mid_ac_ready", resp.ac_ready, 1);
        check("rst_mid_upd", upd_valid, 0);
        check("rst_mid_cr", resp.cr_valid, 0);
        run_snoop(32'h0000_0A00, 4'b0001, 1, 1, 1, mk_line(64'h8800_0000_0000_0088), 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
